// File: rtl/fp32_addsub_resolve.sv
// Final resolve stage of the FP32 add/sub unit: 2-stage valid/ready pipeline producing result, flags, sticky flags.
// Optional macro FP_RESOLVE_NAN_PAYLOAD_EN: propagate the first NaN operand (quieted) instead of the canonical QNAN.
module fp32_addsub_resolve #(
    parameter int          FLAG_W = 3,
    parameter logic [31:0] QNAN   = 32'h7FC0_0000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [31:0]       i_float_A,
    input  logic [31:0]       i_float_B,
    input  logic              i_sub_mode,
    input  logic              i_overflow,
    input  logic              i_zero,
    input  logic              i_NaN,
    input  logic [31:0]       i_raw_result,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [31:0]       o_result,
    output logic [FLAG_W-1:0] o_flags,
    input  logic              i_flag_clear,
    output logic [FLAG_W-1:0] o_sticky_flags
);

    function automatic logic exp_max(input logic [30:0] x);
        return x[30:23] == 8'hFF;
    endfunction

    function automatic logic is_nan(input logic [30:0] x);
        return exp_max(x) && (x[22:0] != 23'd0);
    endfunction

    function automatic logic is_snan(input logic [30:0] x);
        return is_nan(x) && !x[22];
    endfunction

    function automatic logic is_inf(input logic [30:0] x);
        return exp_max(x) && (x[22:0] == 23'd0);
    endfunction

    logic              s1_valid;
    logic              s2_valid;
    logic              s1_advance;
    logic [31:0]       s1_nan_res;
    logic [31:0]       s1_raw;
    logic              s1_nan;
    logic              s1_ovf;
    logic              s1_zero;
    logic              s1_sign_a;
    logic              s1_sign_b;
    logic              s1_inf_a;
    logic              s1_inf_b;
    logic              s1_snan_any;
    logic              s1_nan_any;
    logic [31:0]       nan_pick;
    logic [31:0]       res_next;
    logic [FLAG_W-1:0] flags_next;
    logic              transfer;

    assign s1_advance = ~s2_valid | i_ready;
    assign o_ready    = ~s1_valid | s1_advance;
    assign o_valid    = s2_valid;
    assign transfer   = s2_valid & i_ready;

    // The NaN result pattern is chosen at the input so stage 1 need not keep full operands.
    always_comb begin
        nan_pick = QNAN;
`ifdef FP_RESOLVE_NAN_PAYLOAD_EN
        if (is_nan(i_float_A[30:0])) begin
            nan_pick = i_float_A | 32'h0040_0000;
        end else if (is_nan(i_float_B[30:0])) begin
            nan_pick = i_float_B | 32'h0040_0000;
        end
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid    <= 1'b0;
            s1_nan_res  <= 32'd0;
            s1_raw      <= 32'd0;
            s1_nan      <= 1'b0;
            s1_ovf      <= 1'b0;
            s1_zero     <= 1'b0;
            s1_sign_a   <= 1'b0;
            s1_sign_b   <= 1'b0;
            s1_inf_a    <= 1'b0;
            s1_inf_b    <= 1'b0;
            s1_snan_any <= 1'b0;
            s1_nan_any  <= 1'b0;
        end else if (o_ready) begin
            s1_valid <= i_valid;
            if (i_valid) begin
                s1_nan_res  <= nan_pick;
                s1_raw      <= i_raw_result;
                s1_nan      <= i_NaN;
                s1_ovf      <= i_overflow;
                s1_zero     <= i_zero;
                s1_sign_a   <= i_float_A[31];
                s1_sign_b   <= i_float_B[31] ^ i_sub_mode;
                s1_inf_a    <= is_inf(i_float_A[30:0]);
                s1_inf_b    <= is_inf(i_float_B[30:0]);
                s1_snan_any <= is_snan(i_float_A[30:0]) | is_snan(i_float_B[30:0]);
                s1_nan_any  <= is_nan(i_float_A[30:0]) | is_nan(i_float_B[30:0]);
            end
        end
    end

    // Detector flags may overlap; NaN beats overflow beats zero beats the raw datapath result.
    always_comb begin
        res_next   = s1_raw;
        flags_next = {1'b0, s1_raw[30:23] == 8'hFF, s1_raw[30:0] == 31'd0};
        if (s1_nan) begin
            res_next   = s1_nan_res;
            flags_next = {s1_snan_any | (s1_inf_a & s1_inf_b & ~s1_nan_any), 2'b00};
        end else if (s1_ovf) begin
            res_next   = {(s1_inf_a ? s1_sign_a : s1_sign_b), 8'hFF, 23'd0};
            flags_next = 3'b000;
        end else if (s1_zero) begin
            res_next   = {s1_sign_a & s1_sign_b, 31'd0};
            flags_next = 3'b001;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s2_valid <= 1'b0;
            o_result <= 32'd0;
            o_flags  <= '0;
        end else if (s1_advance) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                o_result <= res_next;
                o_flags  <= flags_next;
            end
        end
    end

    // A clear in the same cycle as a transfer keeps only that transfer's flags.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_sticky_flags <= '0;
        end else if (i_flag_clear) begin
            o_sticky_flags <= transfer ? o_flags : '0;
        end else if (transfer) begin
            o_sticky_flags <= o_sticky_flags | o_flags;
        end
    end

endmodule

// File: tb/tb_fp32_addsub_resolve.sv
// Self-checking bench for fp32_addsub_resolve: directed cases, backpressure, mid-burst reset, random traffic vs a scoreboard.
// Honours FP_RESOLVE_NAN_PAYLOAD_EN when computing expected NaN results.
module tb_fp32_addsub_resolve;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_float_A;
    logic [31:0] i_float_B;
    logic        i_sub_mode;
    logic        i_overflow;
    logic        i_zero;
    logic        i_NaN;
    logic [31:0] i_raw_result;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_result;
    logic [2:0]  o_flags;
    logic        i_flag_clear;
    logic [2:0]  o_sticky_flags;

    int          checks = 0;
    int          failures = 0;
    logic [34:0] sb_q[$];
    logic [2:0]  sticky_m;

    fp32_addsub_resolve dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_float_A(i_float_A), .i_float_B(i_float_B), .i_sub_mode(i_sub_mode),
        .i_overflow(i_overflow), .i_zero(i_zero), .i_NaN(i_NaN), .i_raw_result(i_raw_result),
        .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result), .o_flags(o_flags),
        .i_flag_clear(i_flag_clear), .o_sticky_flags(o_sticky_flags)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic bit f_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 0);
    endfunction

    function automatic bit f_inf(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] == 0);
    endfunction

    // Expected {flags, result} straight from the resolution rules.
    function automatic logic [34:0] ref_model(input logic [31:0] a, input logic [31:0] b, input bit sub,
                                              input bit ovf, input bit zero, input bit nan, input logic [31:0] raw);
        bit          sb;
        bit          nv;
        logic [31:0] r;
        sb = b[31] ^ sub;
        if (nan) begin
            nv = (f_nan(a) && !a[22]) || (f_nan(b) && !b[22]) || (f_inf(a) && f_inf(b));
            r  = QNAN;
`ifdef FP_RESOLVE_NAN_PAYLOAD_EN
            if (f_nan(a)) r = a | 32'h0040_0000;
            else if (f_nan(b)) r = b | 32'h0040_0000;
`endif
            return {nv, 2'b00, r};
        end
        if (ovf) return {3'b000, (f_inf(a) ? a[31] : sb), 8'hFF, 23'd0};
        if (zero) return {3'b001, a[31] & sb, 31'd0};
        return {1'b0, raw[30:23] == 8'hFF, raw[30:0] == 0, raw};
    endfunction

    task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b, input bit sub,
                                  input bit ovf, input bit zero, input bit nan, input logic [31:0] raw);
        i_valid      = 1'b1;
        i_float_A    = a;
        i_float_B    = b;
        i_sub_mode   = sub;
        i_overflow   = ovf;
        i_zero       = zero;
        i_NaN        = nan;
        i_raw_result = raw;
    endtask

    // One clock: check handshake and output against the scoreboard, then advance past the edge.
    task automatic run_cycle(output bit acc);
        logic [34:0] item;
        logic [2:0]  xf;
        #1;
        check_output("o_ready", o_ready, (sb_q.size() < 2) || i_ready);
        xf = 3'b000;
        if (o_valid) begin
            if (sb_q.size() == 0) begin
                check_output("spurious_valid", o_valid, 1'b0);
            end else begin
                item = sb_q[0];
                check_output("result", o_result, item[31:0]);
                check_output("flags", o_flags, item[34:32]);
                if (i_ready) begin
                    xf = item[34:32];
                    void'(sb_q.pop_front());
                end
            end
        end
        acc = i_valid && o_ready;
        if (acc) sb_q.push_back(ref_model(i_float_A, i_float_B, i_sub_mode, i_overflow, i_zero, i_NaN, i_raw_result));
        sticky_m = i_flag_clear ? xf : (sticky_m | xf);
        @(posedge i_clk);
        #1;
        check_output("sticky", o_sticky_flags, sticky_m);
    endtask

    task automatic one_shot(input string tag, input logic [31:0] a, input logic [31:0] b, input bit sub,
                            input bit ovf, input bit zero, input bit nan, input logic [31:0] raw,
                            input logic [31:0] exp_res, input logic [2:0] exp_flags);
        bit acc;
        i_ready = 1'b1;
        apply_stimulus(a, b, sub, ovf, zero, nan, raw);
        run_cycle(acc);
        check_output({tag, "_accept"}, acc, 1'b1);
        check_output({tag, "_lat1"}, o_valid, 1'b0);
        i_valid = 1'b0;
        run_cycle(acc);
        check_output({tag, "_lat2"}, o_valid, 1'b1);
        check_output({tag, "_res"}, o_result, exp_res);
        check_output({tag, "_flg"}, o_flags, exp_flags);
        run_cycle(acc);
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 9))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'h7F80_0000;
            3: return 32'hFF80_0000;
            4: return 32'h7FC0_0000;
            5: return 32'h7F80_0001;
            6: return 32'hFFA0_0005;
            7: return 32'h3F80_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bit acc;
        int accepted;
        logic [31:0] snan_exp;
`ifdef FP_RESOLVE_NAN_PAYLOAD_EN
        snan_exp = 32'h7FC0_0001;
`else
        snan_exp = QNAN;
`endif
        i_rst_n = 1'b0;
        i_ready = 1'b1;
        i_flag_clear = 1'b0;
        sticky_m = 3'b000;
        apply_stimulus(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        i_valid = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        check_output("rst_valid", o_valid, 1'b0);
        check_output("rst_result", o_result, 32'd0);
        check_output("rst_flags", o_flags, 3'b000);
        check_output("rst_sticky", o_sticky_flags, 3'b000);
        i_rst_n = 1'b1;

        one_shot("add", 32'h3F80_0000, 32'h4000_0000, 0, 0, 0, 0, 32'h4040_0000, 32'h4040_0000, 3'b000);
        one_shot("infinf", 32'h7F80_0000, 32'h7F80_0000, 1, 0, 0, 1, 32'd0, QNAN, 3'b100);
        check_output("sticky_nv", o_sticky_flags, 3'b100);
        one_shot("snan", 32'h7F80_0001, 32'h3F80_0000, 0, 0, 0, 1, 32'd0, snan_exp, 3'b100);
        one_shot("nz_sub_pz", 32'h8000_0000, 32'h0000_0000, 1, 0, 1, 0, 32'd0, 32'h8000_0000, 3'b001);
        one_shot("nz_add_pz", 32'h8000_0000, 32'h0000_0000, 0, 0, 1, 0, 32'd0, 32'h0000_0000, 3'b001);
        one_shot("nz_add_nz", 32'h8000_0000, 32'h8000_0000, 0, 0, 1, 0, 32'd0, 32'h8000_0000, 3'b001);
        check_output("sticky_nv_zr", o_sticky_flags, 3'b101);
        one_shot("raw_of", 32'h3F80_0000, 32'h3F80_0000, 0, 0, 0, 0, 32'h7F80_0000, 32'h7F80_0000, 3'b010);
        one_shot("ovf_inf", 32'h3F80_0000, 32'hFF80_0000, 1, 1, 0, 0, 32'd0, 32'h7F80_0000, 3'b000);
        i_flag_clear = 1'b1;
        run_cycle(acc);
        i_flag_clear = 1'b0;
        check_output("sticky_clear", o_sticky_flags, 3'b000);

        // Backpressure burst: six ops, downstream stalled for four cycles.
        accepted = 0;
        i_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (accepted == 0) apply_stimulus(32'h7F80_0001, 32'd0, 0, 0, 0, 1, 32'd0);
            else apply_stimulus(32'h3F80_0000, 32'h3F80_0000, 0, 0, 0, 0, 32'h4000_0000 + accepted);
            run_cycle(acc);
            if (acc) accepted++;
        end
        check_output("bp_accepts", accepted, 2);
        check_output("bp_ready_low", o_ready, 1'b0);
        i_ready = 1'b1;
        i_flag_clear = 1'b1;
        for (int c = 0; c < 20 && accepted < 6; c++) begin
            if (accepted == 3) apply_stimulus(32'd0, 32'd0, 0, 0, 1, 0, 32'd0);
            else apply_stimulus(32'h3F80_0000, 32'h3F80_0000, 0, 0, 0, 0, 32'h4000_0000 + accepted);
            run_cycle(acc);
            if (c == 0) check_output("clear_on_xfer", o_sticky_flags, 3'b100);
            i_flag_clear = 1'b0;
            if (acc) accepted++;
        end
        check_output("bp_all_accepted", accepted, 6);
        i_valid = 1'b0;
        for (int c = 0; c < 20 && sb_q.size() > 0; c++) run_cycle(acc);
        check_output("bp_drained", sb_q.size(), 0);

        // Reset in the middle of a stalled burst.
        i_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            apply_stimulus(32'h3F80_0000, 32'h3F80_0000, 0, 0, 0, 0, 32'h7F80_0000);
            run_cycle(acc);
        end
        i_rst_n = 1'b0;
        #1;
        check_output("midrst_valid", o_valid, 1'b0);
        check_output("midrst_result", o_result, 32'd0);
        check_output("midrst_sticky", o_sticky_flags, 3'b000);
        sb_q.delete();
        sticky_m = 3'b000;
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            run_cycle(acc);
            check_output("post_rst_idle", o_valid, 1'b0);
        end

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            apply_stimulus(rand_operand(), rand_operand(), $urandom_range(0, 1) == 1,
                           $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                           ($urandom_range(0, 3) == 0) ? rand_operand() : $urandom);
            i_valid = $urandom_range(0, 3) != 0;
            i_ready = $urandom_range(0, 3) != 0;
            i_flag_clear = $urandom_range(0, 15) == 0;
            run_cycle(acc);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_flag_clear = 1'b0;
        for (int c = 0; c < 20 && sb_q.size() > 0; c++) run_cycle(acc);
        check_output("rand_drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp32_addsub_resolve.md
Name: fp32_addsub_resolve

Overview:
- Final stage of the FP32 add/sub unit. Sits directly downstream of the special-value exception detector and the normalise/round datapath.
- Consumes the detector's NaN/overflow/zero flags, the original operands and the raw datapath result.
- Produces the IEEE-754 final result plus per-result and sticky exception flags.
- Implemented as a 2-stage valid/ready pipeline with full backpressure.

Parameters:
- FLAG_W, 3, width of flag vectors {NV, OF, ZR}
- QNAN, 32'h7FC0_0000, canonical quiet NaN pattern

Ports:
- i_clk  input  1  clock, rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_valid  input  1  upstream has an operation
- o_ready  output  1  stage 1 can accept
- i_float_A  input  32  operand A
- i_float_B  input  32  operand B
- i_sub_mode  input  1  1 = A-B, 0 = A+B
- i_overflow  input  1  detector: an operand is infinity (not NaN case)
- i_zero  input  1  detector: both operands zero
- i_NaN  input  1  detector: NaN input, or inf-inf with sub
- i_raw_result  input  32  rounded datapath result
- o_valid  output  1  o_result/o_flags valid
- i_ready  input  1  downstream accepts
- o_result  output  32  final FP32 result
- o_flags  output  3  {NV, OF, ZR} for this result
- i_flag_clear  input  1  clear sticky flags
- o_sticky_flags  output  3  OR-accumulated flags since last clear

Behaviour:
- Reset (async, i_rst_n low): both stage valids = 0, o_valid = 0, o_result = 0, o_flags = 0, o_sticky_flags = 0. Data registers are also cleared.
- Reset mid-operation discards in-flight data. No output appears after reset release until a new accept.
- Handshake:
  - Accept when i_valid & o_ready.
  - Output transfer when o_valid & i_ready.
  - o_ready = ~s1_valid | s1_advance.
  - s1_advance = ~s2_valid | i_ready.
  - Full throughput is 1/cycle. Latency is 2 cycles from accept to o_valid with no stall.
  - o_result and o_flags hold stable while o_valid & ~i_ready. No combinational path from i_valid to o_ready.
- Stage 1 registers all inputs and classifies them:
  - sNaN = exp==FF & mant!=0 & mant[22]==0.
  - infA, infB and effective sign of B: sB = B[31]^i_sub_mode.
- Stage 2 resolves the result, by priority:
  1. i_NaN: result = QNAN. NV = 1 if either operand is an sNaN, or (infA & infB & neither is NaN).
  2. i_overflow: result = {sign, 8'hFF, 23'h0}. sign = A[31] if infA, else sB. Flags are all 0 (exact infinity).
  3. i_zero: result = {A[31] & sB, 31'h0}. Round-to-nearest signed-zero rule. ZR = 1.
  4. Otherwise: result = i_raw_result.
     - OF = 1 if raw exp==FF.
     - ZR = 1 if raw[30:0]==0.
- Detector flags are trusted as mutually exclusive-by-priority; the priority order above resolves any overlap.
- Sticky flags:
  - On each output transfer: sticky |= o_flags.
  - i_flag_clear zeroes sticky.
  - Clear and transfer in the same cycle: sticky = o_flags of that transfer (clear first, then set).
- Stall with a full pipe: neither stage advances, and no data is lost or duplicated.

Optional Feature:
- Macro FP_RESOLVE_NAN_PAYLOAD_EN.
- Defined: the NaN case propagates the first NaN operand (A before B), quieted by forcing bit 22 = 1. Sign and payload are kept. inf-inf with no NaN operand still yields QNAN.
- Undefined: every NaN result is QNAN.
- NV behaviour is identical in both builds.

Test Plan:
- Plain add, A=3F800000, B=40000000, i_raw_result=40400000, all detector flags 0 -> o_result=40400000, o_flags=000, o_valid exactly 2 cycles after accept.
- inf-inf: A=7F800000, B=7F800000, sub=1, i_NaN=1 -> o_result=7FC00000, flags NV=1. Sticky NV=1 persists until i_flag_clear.
- sNaN A=7F800001, B=3F800000, i_NaN=1 -> NV=1. Result is 7FC00000; with FP_RESOLVE_NAN_PAYLOAD_EN it is 7FC00001.
- Signed zero cases:
  - A=80000000, B=00000000, sub=1 -> 80000000, ZR=1.
  - Same operands with sub=0 -> 00000000.
  - A=B=80000000, add -> 80000000.
- Overflow and infinity cases:
  - i_raw_result=7F800000 with no detector flags -> OF=1.
  - A=3F800000, B=FF800000, sub=1, i_overflow=1 -> 7F800000, flags 000.
- Backpressure: 6 back-to-back accepts while i_ready=0 for 4 cycles then 1 -> o_ready drops after 2 accepts. All 6 results emerge in order with no loss or duplicates. Asserting i_flag_clear on a transfer cycle leaves sticky = that transfer's flags. Asserting i_rst_n low mid-burst gives o_valid=0 immediately.
